// File: rtl/cache_ctrl_pkg.sv
// ============================================================================
// cache_ctrl_pkg
// Shared geometry, address-field helpers and FSM encoding for the direct-mapped
// cache controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cache_ctrl_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int LINE_WORDS     = 4;
    localparam int INDEX_LENGTH   = 8;
    localparam int CACHE_LINE_NUM = 1 << INDEX_LENGTH;
    localparam int INDEX_W        = INDEX_LENGTH;
    localparam int WORD_W         = $clog2(LINE_WORDS);
    localparam int TAG_LENGTH     = ADDR_W - INDEX_W - WORD_W - 2;
    localparam int TAG_W          = TAG_LENGTH;

    // Controller states: request decode, line invalidate, line refill, write-through
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INVAL  = 2'd1,
        S_REFILL = 2'd2,
        S_WRITE  = 2'd3
    } cache_state_e;

    // Address split: [1:0] byte, then word-in-line, then line index, then tag
    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WORD_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[2 + WORD_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
// cache_ctrl
// Direct-mapped cache controller: hit detection against externally held
// valid/tag/data arrays, word-by-word line refill on read miss, write-through
// without write-allocate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    // CPU side
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    // Memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    // Array side
    output logic [INDEX_W-1:0]  index,
    output logic [WORD_W-1:0]   word_sel,
    output logic                valid_w_en,
    output logic                valid_in,
    input  logic                valid_out,
    output logic                tag_w_en,
    output logic [TAG_W-1:0]    tag_in,
    input  logic [TAG_W-1:0]    tag_out,
    output logic                data_w_en,
    output logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W-1:0]   data_out
);

    cache_state_e            state_q, state_d;
    logic [WORD_W-1:0]       word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:2]       addr_q, addr_d;     // byte offset is never needed
    logic [DATA_W-1:0]       wdata_q, wdata_d;

    logic [ADDR_W-1:0]       lat_addr;
    logic                    hit;
    logic                    byte_off_unused;

    assign lat_addr        = {addr_q, 2'b00};
    assign byte_off_unused = ^cpu_addr[1:0];

    // Hit is only meaningful in IDLE, where the arrays are indexed by cpu_addr
    assign hit       = valid_out && (tag_out == addr_tag(cpu_addr));
    assign cpu_rdata = data_out;

    // State, refill counter and latched request; async active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next-state and all outputs; defaults keep every enable and mem_req low
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        cpu_stall  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        index      = addr_index(lat_addr);
        word_sel   = addr_word(lat_addr);
        valid_w_en = 1'b0;
        valid_in   = 1'b0;
        tag_w_en   = 1'b0;
        tag_in     = addr_tag(lat_addr);
        data_w_en  = 1'b0;
        data_in    = '0;

        case (state_q)
            S_IDLE: begin
                index    = addr_index(cpu_addr);
                word_sel = addr_word(cpu_addr);
                if (cpu_req) begin
                    if (cpu_we) begin
                        // Write-through: update the line now only if it is present
                        cpu_stall = 1'b1;
                        addr_d    = cpu_addr[ADDR_W-1:2];
                        wdata_d   = cpu_wdata;
                        state_d   = S_WRITE;
                        if (hit) begin
                            data_w_en = 1'b1;
                            data_in   = cpu_wdata;
                        end
                    end else if (!hit) begin
                        cpu_stall = 1'b1;
                        addr_d    = cpu_addr[ADDR_W-1:2];
                        state_d   = S_INVAL;
                    end
                end
            end

            S_INVAL: begin
                // Drop the old line first so a half-refilled line never looks valid
                cpu_stall  = 1'b1;
                valid_w_en = 1'b1;
                valid_in   = 1'b0;
                word_cnt_d = '0;
                state_d    = S_REFILL;
            end

            S_REFILL: begin
                cpu_stall = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b0;
                mem_addr  = {addr_tag(lat_addr), addr_index(lat_addr), word_cnt_q, 2'b00};
                word_sel  = word_cnt_q;
                if (mem_ready) begin
                    data_w_en  = 1'b1;
                    data_in    = mem_rdata;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WORD_W'(LINE_WORDS - 1)) begin
                        tag_w_en   = 1'b1;
                        valid_w_en = 1'b1;
                        valid_in   = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = lat_addr;
                mem_wdata = wdata_q;
                cpu_stall = !mem_ready;
                if (mem_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held nothing may reach memory or the arrays
        if (!rst) begin
            mem_req    = 1'b0;
            valid_w_en = 1'b0;
            tag_w_en   = 1'b0;
            data_w_en  = 1'b0;
        end
    end

endmodule

`default_nettype wire
